// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, controller states and lane-offset width helper for data_mem_ctrl.
package dmem_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  function automatic int byte_off_bits(input int word_width);
    return $clog2(word_width / 8);
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for sub-word stores and extending loads.
// The offset is always naturally aligned here; the top decides whether misalignment is a fault.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  localparam int NB = WORD_WIDTH / 8,
  localparam int OFFW = byte_off_bits(WORD_WIDTH)
) (
  input  logic [OFFW-1:0]       i_off,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  input  logic [WORD_WIDTH-1:0] i_rdata,
  output logic [NB-1:0]         o_be,
  output logic [WORD_WIDTH-1:0] o_wdata,
  output logic [WORD_WIDTH-1:0] o_rdata,
  output logic                  o_misalign
);
  logic [OFFW-1:0]       w_mask;
  logic [OFFW-1:0]       w_off;
  logic [WORD_WIDTH-1:0] w_sh;
  logic                  w_sign;
  int                    w_sidx;
  always_comb begin
    w_mask = ~({OFFW{1'b1}} << i_size);
    w_off = i_off & ~w_mask;
    o_misalign = |(i_off & w_mask);
    o_wdata = i_wdata << {w_off, 3'b000};
    w_sh = i_rdata >> {w_off, 3'b000};
    // clamp keeps an illegal size from indexing past the word; that access errors out anyway
    w_sidx = ((8 << i_size) - 1 > WORD_WIDTH - 1) ? WORD_WIDTH - 1 : (8 << i_size) - 1;
    w_sign = 1'b0;
    for (int i = 0; i < WORD_WIDTH; i++) if (i == w_sidx) w_sign = w_sh[i] & ~i_unsigned;
    for (int i = 0; i < WORD_WIDTH; i++) o_rdata[i] = (i <= w_sidx) ? w_sh[i] : w_sign;
    for (int b = 0; b < NB; b++) o_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + (1 << i_size));
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable data memory with valid/ready channels and hardware zero-init.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned accesses instead of force-aligning them.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);
  localparam int NB = WORD_WIDTH / 8;
  localparam int OFFW = byte_off_bits(WORD_WIDTH);
  localparam int IDXW = $clog2(DEPTH);
  state_t                r_state, w_next;
  logic [IDXW-1:0]       r_cnt;
  logic [WORD_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_rsp_valid, r_rsp_err;
  logic [WORD_WIDTH-1:0] r_rsp_rdata;
  logic [IDXW-1:0]       w_idx;
  logic                  w_last, w_oor, w_bad_sz, w_misalign, w_err, w_acc, w_store;
  logic [NB-1:0]         w_be;
  logic [WORD_WIDTH-1:0] w_wdata_sh, w_rdata_ext;
  assign w_idx = req_addr[OFFW+IDXW-1:OFFW];
  assign w_oor = |req_addr[ADDR_WIDTH-1:OFFW+IDXW];
  assign w_bad_sz = (32'd8 << req_size) > 32'(WORD_WIDTH);
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_err = w_oor | w_bad_sz | w_misalign;
`else
  assign w_err = w_oor | w_bad_sz;
`endif
  assign w_last = r_cnt == IDXW'(DEPTH - 1);
  assign init_done = r_state == ST_RUN;
  assign req_ready = init_done && (!r_rsp_valid || rsp_ready);
  assign w_acc = req_valid && req_ready;
  assign w_store = w_acc && req_write && !w_err;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err = r_rsp_err;
  dmem_lane_align #(.WORD_WIDTH(WORD_WIDTH)) u_align (
    .i_off(req_addr[OFFW-1:0]),
    .i_size(req_size),
    .i_unsigned(req_unsigned),
    .i_wdata(req_wdata),
    .i_rdata(r_mem[w_idx]),
    .o_be(w_be),
    .o_wdata(w_wdata_sh),
    .o_rdata(w_rdata_ext),
    .o_misalign(w_misalign)
  );
  always_comb begin
    w_next = (r_state == ST_INIT && w_last) ? ST_RUN : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT && !w_last) r_cnt <= r_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) r_mem[r_cnt] <= '0;
    else if (w_store)
      for (int b = 0; b < NB; b++) if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_acc) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err <= w_err;
      r_rsp_rdata <= (w_err || req_write) ? '0 : w_rdata_ext;
    end else if (rsp_ready) r_rsp_valid <= 1'b0;
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vectors for data_mem_ctrl with hand-computed expectations.
module tb_data_mem_ctrl;
  import dmem_pkg::*;
  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        err;
  } op_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
  logic [1:0]  req_size = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, init_done;
  int          n_chk = 0, n_err = 0, n_init;
  op_t         ops [8];
  always #5 clk = ~clk;
  data_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic set_op(input int i, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input logic [31:0] exp, input logic err);
    ops[i] = '{wr, a, sz, u, wd, exp, err};
  endtask
  task automatic wait_init(output int n);
    int bad = 0;
    n = 0;
    while (!init_done && n < 2000) begin
      if (req_ready) bad++;
      @(posedge clk);
      #1 n++;
    end
    chk("rdy_in_init", bad, 0);
  endtask
  // issues ops[0..n-1] as a stream, holding rsp_ready low for the first `stall` cycles
  task automatic run(input int n, input int stall);
    int k = 0, g = 0, cyc = 0;
    logic acc;
    while ((k < n || g < n) && cyc < 100) begin
      req_valid = k < n;
      if (k < n) begin
        req_write = ops[k].wr; req_addr = ops[k].a; req_size = ops[k].sz;
        req_unsigned = ops[k].u; req_wdata = ops[k].wd;
      end
      rsp_ready = cyc >= stall;
      @(negedge clk);
      if (stall > 1 && cyc == 1) chk("rdy_drop", req_ready, 0);
      if (rsp_valid) begin
        if (g < n) begin
          chk($sformatf("rdata%0d@%h", g, ops[g].a), rsp_rdata, ops[g].exp);
          chk($sformatf("err%0d@%h", g, ops[g].a), rsp_err, ops[g].err);
          if (rsp_ready) g++;
        end else chk("extra_rsp", rsp_valid, 0);
      end
      acc = req_valid && req_ready;
      @(posedge clk);
      #1 if (acc) k++;
      cyc++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("rsp_count", g, n);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_init_done", init_done, 0);
    rst_n = 1'b1;
    wait_init(n_init);
    chk("init_cycles", n_init, 1024);
    set_op(0, 0, 32'h10, SZ_W, 0, 0, 32'h0, 0);
    set_op(1, 1, 32'h4, SZ_W, 0, 32'h11223344, 32'h0, 0);
    set_op(2, 1, 32'h5, SZ_B, 0, 32'hFFFFFFAA, 32'h0, 0);
    set_op(3, 0, 32'h4, SZ_W, 0, 0, 32'h1122AA44, 0);
    set_op(4, 0, 32'h5, SZ_B, 0, 0, 32'hFFFFFFAA, 0);
    set_op(5, 0, 32'h5, SZ_B, 1, 0, 32'h000000AA, 0);
    set_op(6, 1, 32'h8, SZ_H, 0, 32'h00008001, 32'h0, 0);
    set_op(7, 0, 32'h8, SZ_H, 0, 0, 32'hFFFF8001, 0);
    run(8, 0);
    set_op(0, 0, 32'h8, SZ_H, 1, 0, 32'h00008001, 0);
    set_op(1, 0, 32'h1000, SZ_W, 0, 0, 32'h0, 1);
    set_op(2, 0, 32'h0, SZ_D, 0, 0, 32'h0, 1);
    set_op(3, 1, 32'h20, SZ_W, 0, 32'hA0A1A2A3, 32'h0, 0);
    set_op(4, 1, 32'h24, SZ_W, 0, 32'hB0B1B2B3, 32'h0, 0);
    set_op(5, 1, 32'h1000, SZ_W, 0, 32'h12345678, 32'h0, 1);
    set_op(6, 0, 32'h0, SZ_W, 0, 0, 32'h0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    set_op(7, 1, 32'h2, SZ_W, 0, 32'hDEADBEEF, 32'h0, 1);
`else
    set_op(7, 1, 32'h2, SZ_W, 0, 32'hDEADBEEF, 32'h0, 0);
`endif
    run(8, 0);
    set_op(0, 0, 32'h20, SZ_W, 0, 0, 32'hA0A1A2A3, 0);
    set_op(1, 0, 32'h24, SZ_W, 0, 0, 32'hB0B1B2B3, 0);
    set_op(2, 0, 32'h24, SZ_B, 1, 0, 32'h000000B3, 0);
    set_op(3, 0, 32'h26, SZ_H, 0, 0, 32'hFFFFB0B1, 0);
    run(4, 3);
`ifdef DMEM_ALIGN_CHECK_EN
    set_op(0, 0, 32'h0, SZ_W, 0, 0, 32'h0, 0);
`else
    set_op(0, 0, 32'h0, SZ_W, 0, 0, 32'hDEADBEEF, 0);
`endif
    set_op(1, 1, 32'h30, SZ_W, 0, 32'h55667788, 32'h0, 0);
    set_op(2, 0, 32'h30, SZ_W, 0, 0, 32'h55667788, 0);
    set_op(3, 0, 32'h1000, SZ_B, 1, 0, 32'h0, 1);
    run(4, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4; req_size = SZ_W; req_unsigned = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("stall_valid", rsp_valid, 1);
    chk("stall_rdata", rsp_rdata, 32'h1122AA44);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drop_valid", rsp_valid, 0);
    chk("rst_drop_init", init_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    wait_init(n_init);
    chk("reinit_cycles", n_init, 1024);
    set_op(0, 0, 32'h4, SZ_W, 0, 0, 32'h0, 0);
    set_op(1, 0, 32'h8, SZ_W, 0, 0, 32'h0, 0);
    set_op(2, 0, 32'h20, SZ_W, 0, 0, 32'h0, 0);
    run(3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
